// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants and status encoding for the parking slot manager
// Contents: status_e (lot status encoding), NUM_SLOTS_DEFAULT, STATS_W.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } status_e;

    localparam int NUM_SLOTS_DEFAULT = 8;
    localparam int STATS_W           = 16;

endpackage

// File: rtl/parking_free_slot_finder.sv
// rtl/parking_free_slot_finder.sv - combinational lowest-zero priority encoder
// Ports:
//   occupancy  in   NUM_SLOTS  bit i=1 means slot i is taken
//   found      out  1          at least one slot is free
//   index      out  IDX_W      lowest free slot index (0 when none free)
module parking_free_slot_finder #(
    parameter int  NUM_SLOTS = 8,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic                 found,
    output logic [IDX_W-1:0]     index
);

    // Scan from the top down so the lowest free slot is the last to win.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                found = 1'b1;
                index = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/parking_slot_manager.sv
// rtl/parking_slot_manager.sv - parking-lot slot allocator with free count and lot status
// Optional feature macro: PARKING_STATS_EN (adds total_entries / total_refusals).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   enter_req                     car arrival request
//   enter_ack / enter_nack        grant / lot-full refusal pulses
//   enter_slot                    granted slot, held between grants
//   exit_req, exit_slot           car departure request and slot being vacated
//   exit_ack / exit_err           release / invalid-release pulses
//   park_location                 occupancy vector
//   free_count                    number of free slots
//   lot_full, lot_empty           lot status flags
//   total_entries, total_refusals saturating statistics (PARKING_STATS_EN only)
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int  NUM_SLOTS = NUM_SLOTS_DEFAULT,
    localparam int IDX_W     = $clog2(NUM_SLOTS),
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enter_req,
    output logic                 enter_ack,
    output logic                 enter_nack,
    output logic [IDX_W-1:0]     enter_slot,
    input  logic                 exit_req,
    input  logic [IDX_W-1:0]     exit_slot,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] park_location,
    output logic [CNT_W-1:0]     free_count,
    output logic                 lot_full,
    output logic                 lot_empty
`ifdef PARKING_STATS_EN
    ,
    output logic [STATS_W-1:0]   total_entries,
    output logic [STATS_W-1:0]   total_refusals
`endif
);

    localparam logic [CNT_W-1:0] ALL_FREE  = NUM_SLOTS[CNT_W-1:0];
    localparam logic [IDX_W:0]   SLOTS_EXT = NUM_SLOTS[IDX_W:0];

    logic                 slot_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 grant;
    logic                 refuse;
    logic                 exit_in_range;
    logic [NUM_SLOTS-1:0] exit_shifted;
    logic                 release_ok;
    logic                 release_bad;
    logic [NUM_SLOTS-1:0] set_mask;
    logic [NUM_SLOTS-1:0] clr_mask;
    logic [NUM_SLOTS-1:0] next_occ;
    logic [CNT_W-1:0]     next_free;
    status_e              status_q;
    status_e              status_d;

    // Entry is judged against occupancy before this cycle's exit, so a slot
    // being vacated now is still seen as taken and is never handed out.
    parking_free_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_finder (
        .occupancy (park_location),
        .found     (slot_found),
        .index     (free_idx)
    );

    assign grant  = enter_req & slot_found;
    assign refuse = enter_req & ~slot_found;

    // The shift avoids indexing past the vector when exit_slot is out of range.
    assign exit_in_range = ({1'b0, exit_slot} < SLOTS_EXT);
    assign exit_shifted  = park_location >> exit_slot;
    assign release_ok    = exit_req & exit_in_range & exit_shifted[0];
    assign release_bad   = exit_req & ~release_ok;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (grant) begin
            set_mask = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << free_idx;
        end
        if (release_ok) begin
            clr_mask = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << exit_slot;
        end
        next_occ = (park_location | set_mask) & ~clr_mask;
    end

    // A grant and a release in the same cycle cancel out.
    always_comb begin
        next_free = free_count;
        if (grant && !release_ok) begin
            next_free = free_count - 1'b1;
        end else if (!grant && release_ok) begin
            next_free = free_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            park_location <= '0;
            free_count    <= ALL_FREE;
            enter_ack     <= 1'b0;
            enter_nack    <= 1'b0;
            enter_slot    <= '0;
            exit_ack      <= 1'b0;
            exit_err      <= 1'b0;
        end else begin
            park_location <= next_occ;
            free_count    <= next_free;
            enter_ack     <= grant;
            enter_nack    <= refuse;
            exit_ack      <= release_ok;
            exit_err      <= release_bad;
            if (grant) begin
                enter_slot <= free_idx;
            end
        end
    end

    // Lot status FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= ST_EMPTY;
        end else begin
            status_q <= status_d;
        end
    end

    // Lot status FSM: next state follows the count being loaded this edge.
    always_comb begin
        status_d = ST_PARTIAL;
        if (next_free == ALL_FREE) begin
            status_d = ST_EMPTY;
        end else if (next_free == '0) begin
            status_d = ST_FULL;
        end
    end

    // Lot status FSM: outputs.
    always_comb begin
        lot_full  = 1'b0;
        lot_empty = 1'b0;
        case (status_q)
            ST_EMPTY: lot_empty = 1'b1;
            ST_FULL:  lot_full  = 1'b1;
            default:  ;
        endcase
    end

`ifdef PARKING_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_entries  <= '0;
            total_refusals <= '0;
        end else begin
            if (grant && (total_entries != '1)) begin
                total_entries <= total_entries + 1'b1;
            end
            if (refuse && (total_refusals != '1)) begin
                total_refusals <= total_refusals + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_slot_manager.sv
// tb/tb_parking_slot_manager.sv - directed self-checking bench for parking_slot_manager
module tb_parking_slot_manager;

    logic       clk;
    logic       rst_n;

    logic       enter_req;
    logic       enter_ack;
    logic       enter_nack;
    logic [2:0] enter_slot;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       exit_ack;
    logic       exit_err;
    logic [7:0] park_location;
    logic [3:0] free_count;
    logic       lot_full;
    logic       lot_empty;

    logic       e6_req;
    logic       e6_ack;
    logic       e6_nack;
    logic [2:0] e6_slot;
    logic       x6_req;
    logic [2:0] x6_slot;
    logic       x6_ack;
    logic       x6_err;
    logic [5:0] p6_location;
    logic [2:0] f6_count;
    logic       f6_full;
    logic       f6_empty;

`ifdef PARKING_STATS_EN
    logic [15:0] total_entries;
    logic [15:0] total_refusals;
    logic [15:0] t6_entries;
    logic [15:0] t6_refusals;
`endif

    int n_checks;
    int n_fail;

    parking_slot_manager #(
        .NUM_SLOTS (8)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enter_req      (enter_req),
        .enter_ack      (enter_ack),
        .enter_nack     (enter_nack),
        .enter_slot     (enter_slot),
        .exit_req       (exit_req),
        .exit_slot      (exit_slot),
        .exit_ack       (exit_ack),
        .exit_err       (exit_err),
        .park_location  (park_location),
        .free_count     (free_count),
        .lot_full       (lot_full),
        .lot_empty      (lot_empty)
`ifdef PARKING_STATS_EN
        ,
        .total_entries  (total_entries),
        .total_refusals (total_refusals)
`endif
    );

    parking_slot_manager #(
        .NUM_SLOTS (6)
    ) u_dut6 (
        .clk            (clk),
        .rst_n          (rst_n),
        .enter_req      (e6_req),
        .enter_ack      (e6_ack),
        .enter_nack     (e6_nack),
        .enter_slot     (e6_slot),
        .exit_req       (x6_req),
        .exit_slot      (x6_slot),
        .exit_ack       (x6_ack),
        .exit_err       (x6_err),
        .park_location  (p6_location),
        .free_count     (f6_count),
        .lot_full       (f6_full),
        .lot_empty      (f6_empty)
`ifdef PARKING_STATS_EN
        ,
        .total_entries  (t6_entries),
        .total_refusals (t6_refusals)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle8(input logic en, input logic ex, input logic [2:0] slot);
        enter_req = en;
        exit_req  = ex;
        exit_slot = slot;
        @(posedge clk);
        #1;
        enter_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic cycle6(input logic en, input logic ex, input logic [2:0] slot);
        e6_req  = en;
        x6_req  = ex;
        x6_slot = slot;
        @(posedge clk);
        #1;
        e6_req = 1'b0;
        x6_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev;
        n_checks  = 0;
        n_fail    = 0;
        enter_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = '0;
        e6_req    = 1'b0;
        x6_req    = 1'b0;
        x6_slot   = '0;
        rst_n     = 1'b0;
        #12;
        check("rst_park", park_location, 8'h00);
        check("rst_free", free_count, 4'd8);
        check("rst_empty", lot_empty, 1'b1);
        check("rst_full", lot_full, 1'b0);
        check("rst_slot", enter_slot, 3'd0);
        check("rst_ack", enter_ack, 1'b0);
        check("rst_xerr", exit_err, 1'b0);
        check("rst6_free", f6_count, 3'd6);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill the lot in order.
        for (int i = 0; i < 8; i++) begin
            cycle8(1'b1, 1'b0, 3'd0);
            check("fill_ack", enter_ack, 1'b1);
            check("fill_slot", enter_slot, i[2:0]);
            check("fill_free", free_count, 4'(7 - i));
            check("fill_full", lot_full, (i == 7));
            check("fill_empty", lot_empty, 1'b0);
        end
        cycle8(1'b1, 1'b0, 3'd0);
        check("full_nack", enter_nack, 1'b1);
        check("full_noack", enter_ack, 1'b0);
        check("full_park", park_location, 8'hFF);
        check("full_slot_held", enter_slot, 3'd7);

        cycle8(1'b0, 1'b1, 3'd3);
        check("x3_ack", exit_ack, 1'b1);
        check("x3_park", park_location, 8'hF7);
        check("x3_full", lot_full, 1'b0);
        check("x3_free", free_count, 4'd1);
        cycle8(1'b1, 1'b0, 3'd0);
        check("re3_slot", enter_slot, 3'd3);
        check("re3_park", park_location, 8'hFF);
        check("re3_full", lot_full, 1'b1);

        // Full lot: entry refused even though slot 5 leaves this cycle.
        cycle8(1'b1, 1'b1, 3'd5);
        check("sim_nack", enter_nack, 1'b1);
        check("sim_xack", exit_ack, 1'b1);
        check("sim_park", park_location, 8'hDF);
        check("sim_free", free_count, 4'd1);
        check("sim_full", lot_full, 1'b0);
`ifdef PARKING_STATS_EN
        check("st_entries", total_entries, 16'd9);
        check("st_refusals", total_refusals, 16'd2);
`endif

        // Asynchronous reset between edges, right after a grant.
        enter_req = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_ack", enter_ack, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        enter_req = 1'b0;
        check("arst_park", park_location, 8'h00);
        check("arst_ack", enter_ack, 1'b0);
        check("arst_free", free_count, 4'd8);
        check("arst_empty", lot_empty, 1'b1);
        check("arst_slot", enter_slot, 3'd0);
`ifdef PARKING_STATS_EN
        check("arst_entries", total_entries, 16'd0);
        check("arst_refusals", total_refusals, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle8(1'b0, 1'b1, 3'd2);
        check("xe_err", exit_err, 1'b1);
        check("xe_ack", exit_ack, 1'b0);
        check("xe_park", park_location, 8'h00);
        check("xe_free", free_count, 4'd8);
        check("xe_empty", lot_empty, 1'b1);

        // Partial lot {0,1,2}; enter while slot 1 leaves.
        repeat (3) cycle8(1'b1, 1'b0, 3'd0);
        check("p3_park", park_location, 8'h07);
        cycle8(1'b1, 1'b1, 3'd1);
        check("ps_slot", enter_slot, 3'd3);
        check("ps_ack", enter_ack, 1'b1);
        check("ps_xack", exit_ack, 1'b1);
        check("ps_park", park_location, 8'h0D);
        check("ps_free", free_count, 4'd5);
        cycle8(1'b0, 1'b0, 3'd0);
        check("idle_ack", enter_ack, 1'b0);
        check("idle_xack", exit_ack, 1'b0);
        check("idle_slot", enter_slot, 3'd3);
        cycle8(1'b0, 1'b1, 3'd1);
        check("xfree_err", exit_err, 1'b1);
        check("xfree_park", park_location, 8'h0D);

        // Six-slot lot: non-power-of-two range checks.
        for (int i = 0; i < 6; i++) begin
            cycle6(1'b1, 1'b0, 3'd0);
            check("f6_slot", e6_slot, i[2:0]);
        end
        check("f6_park", p6_location, 6'h3F);
        check("f6_full", f6_full, 1'b1);
        check("f6_free0", f6_count, 3'd0);
        cycle6(1'b1, 1'b0, 3'd0);
        check("f6_nack", e6_nack, 1'b1);
        cycle6(1'b0, 1'b1, 3'd7);
        check("x6_7_err", x6_err, 1'b1);
        check("x6_7_park", p6_location, 6'h3F);
        cycle6(1'b0, 1'b1, 3'd6);
        check("x6_6_err", x6_err, 1'b1);
        cycle6(1'b0, 1'b1, 3'd5);
        check("x6_5_ack", x6_ack, 1'b1);
        check("x6_5_park", p6_location, 6'h1F);
        check("x6_5_free", f6_count, 3'd1);

`ifdef PARKING_STATS_EN
        // Alternate slots 0/1 with simultaneous enter/exit to saturate the entry count.
        apply_reset();
        cycle8(1'b1, 1'b0, 3'd0);
        prev = 3'd0;
        repeat (70000) begin
            cycle8(1'b1, 1'b1, prev);
            prev = (prev == 3'd0) ? 3'd1 : 3'd0;
        end
        check("sat_entries", total_entries, 16'hFFFF);
        check("sat_refusals", total_refusals, 16'd0);
        check("sat_free", free_count, 4'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
Parametrised parking-lot slot controller, the next generation of the fixed 3-to-8 exit decoder.
- Tracks occupancy of NUM_SLOTS spaces in a register.
- On entry, allocates the lowest-index free slot; on exit, releases the requested slot.
- Maintains a free-space count and EMPTY/PARTIAL/FULL lot status.
- Sits between the gate sensors/keypad and the display/barrier logic.

Parameters:
- NUM_SLOTS, 8, number of parking spaces (2..64).
- IDX_W, $clog2(NUM_SLOTS), slot index width; derived, never overridden.
- CNT_W, $clog2(NUM_SLOTS+1), free-count width; derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enter_req  in  1  single-cycle car-arrival request.
- enter_ack  out  1  one-cycle pulse: slot granted.
- enter_nack  out  1  one-cycle pulse: lot full, entry refused.
- enter_slot  out  IDX_W  granted slot index; valid while enter_ack=1, held otherwise.
- exit_req  in  1  single-cycle car-departure request.
- exit_slot  in  IDX_W  slot being vacated; sampled with exit_req.
- exit_ack  out  1  one-cycle pulse: slot released.
- exit_err  out  1  one-cycle pulse: slot index out of range or slot already free.
- park_location  out  NUM_SLOTS  occupancy vector; bit i=1 means slot i is occupied.
- free_count  out  CNT_W  number of free slots.
- lot_full  out  1  status==FULL.
- lot_empty  out  1  status==EMPTY.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values:
  - park_location=0, free_count=NUM_SLOTS.
  - All pulses=0, enter_slot=0.
  - Status FSM=EMPTY, so lot_empty=1 and lot_full=0.
- Registered outputs; one-cycle latency. A request sampled at edge N produces its response after edge N, visible in cycle N+1.
- Entry, evaluated against park_location as it stood before this cycle's exit:
  - If any slot is free: set the lowest-index free bit, enter_slot=that index, enter_ack=1, free_count-1.
  - If no slot is free: enter_nack=1; no state change.
- Exit:
  - exit_slot>=NUM_SLOTS or park_location[exit_slot]==0: exit_err=1; no state change.
  - Otherwise: clear the bit, exit_ack=1, free_count+1.
- Simultaneous enter_req and exit_req:
  - Both are processed in the same cycle.
  - Entry uses pre-exit occupancy, so a full lot refuses entry even if a valid exit occurs that cycle.
  - Net free_count change is 0 when both succeed.
  - An entry can never be granted the slot being vacated in the same cycle, because that slot is still occupied pre-exit.
- free_count never wraps; by construction it stays within 0..NUM_SLOTS.
- Status FSM, next state computed from next free_count:
  - EMPTY: free_count==NUM_SLOTS.
  - FULL: free_count==0.
  - PARTIAL: otherwise.
  - Transitions: EMPTY->PARTIAL on first grant; PARTIAL->FULL on last grant; FULL->PARTIAL on exit; PARTIAL->EMPTY on last exit.
  - With NUM_SLOTS>=2, EMPTY<->FULL cannot occur directly.
- Requests held high are treated as new requests every cycle.
- Reset asserted mid-operation clears everything immediately; any pending pulse is lost.

Optional Feature:
- Macro: PARKING_STATS_EN.
- Defined:
  - Adds output total_entries [15:0]: count of granted entries, saturating at 16'hFFFF.
  - Adds output total_refusals [15:0]: count of enter_nack pulses, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header parking_pkg:
  - Status encoding: ST_EMPTY=2'b00, ST_PARTIAL=2'b01, ST_FULL=2'b10.
  - Default NUM_SLOTS.
  - Stats counter width constant (16).
- Sub-module parking_free_slot_finder: combinational lowest-zero priority encoder, NUM_SLOTS-wide vector -> {found, index}.

Test Plan:
- Reset then NUM_SLOTS=8 back-to-back enter_req -> enter_slot 0..7 in order, free_count 8->0, lot_full=1 after the 8th ack; the 9th request -> enter_nack, park_location=8'hFF.
- Full lot, exit_slot=3 -> exit_ack, park_location=8'hF7, lot_full=0; next enter_req -> enter_slot=3.
- Full lot, enter_req and exit_slot=5 in the same cycle -> enter_nack and exit_ack, park_location=8'hDF, free_count=1.
- From empty, exit_slot=2 -> exit_err, no state change; with NUM_SLOTS=6, exit_slot=7 -> exit_err.
- Partial lot {0,1,2}, simultaneous enter_req and exit_slot=1 -> enter_slot=3, park_location=8'h0D, free_count unchanged at 5.
- rst_n low asynchronously mid-burst -> outputs at reset values before the next edge; with PARKING_STATS_EN, total_entries=0 after reset and saturates at 16'hFFFF under a long enter/exit loop.
